// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative restoring divider (div_unit).
package div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Bit positions inside the div_inst request vector
    localparam int DIV_INST_SSTART = 0;
    localparam int DIV_INST_USTART = 1;
    localparam int DIV_INST_QOP    = 2;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and div_unit.
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic [2:0]      div_inst;
    logic            div_kill;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            hazard_x;
    logic            div_wb;
    logic [XLEN-1:0] Qo;
    logic [XLEN-1:0] Ro;
    logic            RSIGN;

    modport master (
        output div_inst, div_kill, rs1_data, rs2_data,
        input  hazard_x, div_wb, Qo, Ro, RSIGN
    );

    modport slave (
        input  div_inst, div_kill, rs1_data, rs2_data,
        output hazard_x, div_wb, Qo, Ro, RSIGN
    );
endinterface

// File: rtl/div_unit_step.sv
// One combinational restoring-division step: shift {rem,quo}, trial-subtract, keep if non-negative.
module div_step
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] rem_sh_s;
    logic [XLEN:0] diff_s;
    logic          neg_s;

    // The partial remainder stays below the divisor, so XLEN+1 bits hold the sign reliably
    assign rem_sh_s = {rem_i, quo_i[XLEN-1]};
    assign diff_s   = rem_sh_s - {1'b0, divisor_i};
    assign neg_s    = diff_s[XLEN];
    assign rem_o    = neg_s ? rem_sh_s[XLEN-1:0] : diff_s[XLEN-1:0];
    assign quo_o    = {quo_i[XLEN-2:0], ~neg_s};
endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_FAST_PATH_EN skips the iteration for zero divisor, overflow and |a|<|b|.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);
    localparam int              RUN_CYCLES = XLEN / STEPS_PER_CYCLE;
    localparam int              CNT_W      = $clog2(RUN_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [XLEN-1:0] ZERO_V     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ZERO_Q     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] OVF_Q      = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d, dvd_q, dvd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            sgn_q, sgn_d, sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic            zero_q, zero_d, ovf_q, ovf_d;
    logic            hazard_q, hazard_d, wb_q, wb_d, rsign_q, rsign_d;
    logic [XLEN-1:0] qo_q, qo_d, ro_q, ro_d;

    logic            start_s, sgn_s, neg_a_s, neg_b_s, zero_s, ovf_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s;
    logic            unused_qop_s;

    // A request with both start bits set is treated as signed
    assign start_s      = |bus.div_inst[DIV_INST_USTART:DIV_INST_SSTART];
    assign sgn_s        = bus.div_inst[DIV_INST_SSTART];
    assign unused_qop_s = bus.div_inst[DIV_INST_QOP];
    assign neg_a_s      = sgn_s & bus.rs1_data[XLEN-1];
    assign neg_b_s      = sgn_s & bus.rs2_data[XLEN-1];
    assign a_mag_s      = neg_a_s ? -bus.rs1_data : bus.rs1_data;
    assign b_mag_s      = neg_b_s ? -bus.rs2_data : bus.rs2_data;
    assign zero_s       = (bus.rs2_data == ZERO_V);
    assign ovf_s        = sgn_s & (bus.rs1_data == OVF_Q) & (bus.rs2_data == ZERO_Q);

`ifdef DIV_FAST_PATH_EN
    logic small_s;
    assign small_s = (a_mag_s < b_mag_s);
`endif

    logic [XLEN-1:0] rem_c [STEPS_PER_CYCLE+1];
    logic [XLEN-1:0] quo_c [STEPS_PER_CYCLE+1];

    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;

    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem_i     (rem_c[g]),
            .quo_i     (quo_c[g]),
            .divisor_i (dvs_q),
            .rem_o     (rem_c[g+1]),
            .quo_o     (quo_c[g+1])
        );
    end

    // Next-state, datapath and result computation
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        dvd_d    = dvd_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        qo_d     = qo_q;
        ro_d     = ro_q;
        rsign_d  = rsign_q;
        case (state_q)
            IDLE: begin
                if (bus.div_kill) begin
                    state_d = IDLE;
                end else if (start_s) begin
                    sgn_d    = sgn_s;
                    sign_a_d = neg_a_s;
                    sign_b_d = neg_b_s;
                    zero_d   = zero_s;
                    ovf_d    = ovf_s;
                    dvs_d    = b_mag_s;
                    dvd_d    = bus.rs1_data;
                    cnt_d    = {CNT_W{1'b0}};
`ifdef DIV_FAST_PATH_EN
                    if (zero_s || ovf_s || small_s) begin
                        state_d = FIX;
                        rem_d   = a_mag_s;
                        quo_d   = ZERO_V;
                    end else begin
                        state_d = RUN;
                        rem_d   = ZERO_V;
                        quo_d   = a_mag_s;
                    end
`else
                    state_d = RUN;
                    rem_d   = ZERO_V;
                    quo_d   = a_mag_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.div_kill) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_c[STEPS_PER_CYCLE];
                    quo_d = quo_c[STEPS_PER_CYCLE];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIX;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FIX: begin
                if (bus.div_kill) begin
                    state_d = IDLE;
                end else begin
                    // Divide-by-zero wins over overflow and over the sign correction
                    if (zero_q) begin
                        qo_d = ZERO_Q;
                        ro_d = dvd_q;
                    end else if (ovf_q) begin
                        qo_d = OVF_Q;
                        ro_d = ZERO_V;
                    end else if (sgn_q) begin
                        qo_d = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
                        ro_d = sign_a_q ? -rem_q : rem_q;
                    end else begin
                        qo_d = quo_q;
                        ro_d = rem_q;
                    end
                    rsign_d = sign_a_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        hazard_d = (state_d == RUN) || (state_d == FIX);
        wb_d     = (state_d == DONE);
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            rem_q    <= ZERO_V;
            quo_q    <= ZERO_V;
            dvs_q    <= ZERO_V;
            dvd_q    <= ZERO_V;
            cnt_q    <= {CNT_W{1'b0}};
            sgn_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            hazard_q <= 1'b0;
            wb_q     <= 1'b0;
            rsign_q  <= 1'b0;
            qo_q     <= ZERO_V;
            ro_q     <= ZERO_V;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            dvd_q    <= dvd_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            hazard_q <= hazard_d;
            wb_q     <= wb_d;
            rsign_q  <= rsign_d;
            qo_q     <= qo_d;
            ro_q     <= ro_d;
        end
    end

    assign bus.hazard_x = hazard_q;
    assign bus.div_wb   = wb_q;
    assign bus.Qo       = qo_q;
    assign bus.Ro       = ro_q;
    assign bus.RSIGN    = rsign_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at issue, compared on each div_wb pulse.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] qo;
        logic [31:0] ro;
        logic        rsign;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    logic [31:0] last_qo = 32'h0;
    logic [31:0] last_ro = 32'h0;

    div_unit_if #(.XLEN(XLEN)) bus();

    div_unit #(.XLEN(XLEN), .STEPS_PER_CYCLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(logic [2:0] inst, logic [31:0] a, logic [31:0] b, int t);
        exp_t        e;
        logic        sgn;
        logic        ovf;
        logic [31:0] am;
        logic [31:0] bm;
        logic        fast;
        sgn = inst[0];
        ovf = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        am  = (sgn && a[31]) ? (32'h0 - a) : a;
        bm  = (sgn && b[31]) ? (32'h0 - b) : b;
        if (b == 32'h0) begin
            e.qo = DIV_ZERO_Q;
            e.ro = a;
        end else if (ovf) begin
            e.qo = DIV_OVF_Q;
            e.ro = 32'h0;
        end else if (sgn) begin
            e.qo = $signed(a) / $signed(b);
            e.ro = $signed(a) % $signed(b);
        end else begin
            e.qo = a / b;
            e.ro = a % b;
        end
        e.rsign = sgn & a[31];
        fast = (b == 32'h0) || ovf || (am < bm);
`ifdef DIV_FAST_PATH_EN
        e.cyc = t + (fast ? 2 : 34);
`else
        e.cyc = t + (fast ? 34 : 34);
`endif
        return e;
    endfunction

    // Scoreboard: each div_wb pulse pops and checks one expected result
    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (bus.div_wb === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_wb at cycle %0d: got div_wb=1 Qo=%h Ro=%h, required no writeback", cyc, bus.Qo, bus.Ro);
            end else begin
                e = exp_q.pop_front();
                vectors += 4;
                if (bus.Qo !== e.qo) begin
                    miscompares++;
                    $display("FAIL wb_Qo at cycle %0d: got %h, required %h", cyc, bus.Qo, e.qo);
                end
                if (bus.Ro !== e.ro) begin
                    miscompares++;
                    $display("FAIL wb_Ro at cycle %0d: got %h, required %h", cyc, bus.Ro, e.ro);
                end
                if (bus.RSIGN !== e.rsign) begin
                    miscompares++;
                    $display("FAIL wb_RSIGN at cycle %0d: got %b, required %b", cyc, bus.RSIGN, e.rsign);
                end
                if (cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL wb_latency: got cycle %0d, required %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(logic [2:0] inst, logic [31:0] a, logic [31:0] b, bit push);
        exp_t e;
        bus.div_inst = inst;
        bus.rs1_data = a;
        bus.rs2_data = b;
        if (push) begin
            e = model(inst, a, b, cyc);
            exp_q.push_back(e);
            last_qo = e.qo;
            last_ro = e.ro;
        end
    endtask

    task automatic wait_drain(string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.div_inst  = 3'b000;
        bus.div_kill  = 1'b0;
        bus.rs1_data  = 32'h0;
        bus.rs2_data  = 32'h0;
        repeat (3) @(negedge clk);
        vectors += 3;
        if ({bus.hazard_x, bus.div_wb, bus.RSIGN} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 000", {bus.hazard_x, bus.div_wb, bus.RSIGN});
        end
        if (bus.Qo !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_Qo: got %h, required 00000000", bus.Qo);
        end
        if (bus.Ro !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_Ro: got %h, required 00000000", bus.Ro);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_signed();
        int t;
        issue(3'b101, 32'd100, 32'd7, 1'b1);
        t = cyc;
        @(negedge clk);
        bus.div_inst = 3'b000;
        vectors++;
        if (bus.hazard_x !== 1'b1) begin
            miscompares++;
            $display("FAIL hazard_T+1: got %b, required 1", bus.hazard_x);
        end
        repeat (32) @(negedge clk);
        vectors++;
        if ({bus.hazard_x, bus.div_wb} !== 2'b10) begin
            miscompares++;
            $display("FAIL hazard_T+33 at cycle %0d: got %b, required 10", cyc - t, {bus.hazard_x, bus.div_wb});
        end
        @(negedge clk);
        vectors++;
        if ({bus.hazard_x, bus.div_wb} !== 2'b01) begin
            miscompares++;
            $display("FAIL done_T+34: got %b, required 01", {bus.hazard_x, bus.div_wb});
        end
        wait_drain("signed_pos");
        issue(3'b101, 32'hFFFF_FF9C, 32'd7, 1'b1);
        @(negedge clk);
        bus.div_inst = 3'b000;
        wait_drain("signed_neg");
        issue(3'b101, 32'd100, 32'hFFFF_FFF9, 1'b1);
        @(negedge clk);
        bus.div_inst = 3'b000;
        wait_drain("signed_negdiv");
        issue(3'b011, 32'hFFFF_FF9C, 32'd7, 1'b1);
        @(negedge clk);
        bus.div_inst = 3'b000;
        wait_drain("both_start_bits");
    endtask

    task automatic test_unsigned_hold();
        issue(3'b010, 32'hFFFF_FFFF, 32'd2, 1'b1);
        repeat (35) @(negedge clk);
        vectors++;
        if (bus.hazard_x !== 1'b0) begin
            miscompares++;
            $display("FAIL done_no_restart: got hazard_x=%b, required 0", bus.hazard_x);
        end
        bus.div_inst = 3'b000;
        repeat (40) @(negedge clk);
        wait_drain("unsigned_hold");
    endtask

    task automatic test_specials();
        issue(3'b101, 32'hFFFF_FFFB, 32'h0, 1'b1);
        @(negedge clk);
        bus.div_inst = 3'b000;
        wait_drain("signed_div0");
        issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        bus.div_inst = 3'b000;
        wait_drain("signed_ovf");
        issue(3'b010, 32'd5, 32'h0, 1'b1);
        @(negedge clk);
        bus.div_inst = 3'b000;
        wait_drain("unsigned_div0");
    endtask

    task automatic test_kill();
        issue(3'b101, 32'd500, 32'd7, 1'b0);
        @(negedge clk);
        bus.div_inst = 3'b000;
        repeat (9) @(negedge clk);
        bus.div_kill = 1'b1;
        @(negedge clk);
        bus.div_kill = 1'b0;
        vectors += 3;
        if ({bus.hazard_x, bus.div_wb} !== 2'b00) begin
            miscompares++;
            $display("FAIL kill_idle: got %b, required 00", {bus.hazard_x, bus.div_wb});
        end
        if (bus.Qo !== last_qo) begin
            miscompares++;
            $display("FAIL kill_Qo_hold: got %h, required %h", bus.Qo, last_qo);
        end
        if (bus.Ro !== last_ro) begin
            miscompares++;
            $display("FAIL kill_Ro_hold: got %h, required %h", bus.Ro, last_ro);
        end
        @(negedge clk);
        issue(3'b101, 32'd9, 32'd3, 1'b1);
        @(negedge clk);
        bus.div_inst = 3'b000;
        wait_drain("after_kill");
        issue(3'b101, 32'd50, 32'd5, 1'b0);
        bus.div_kill = 1'b1;
        @(negedge clk);
        bus.div_inst = 3'b000;
        bus.div_kill = 1'b0;
        vectors++;
        if (bus.hazard_x !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_beats_start: got hazard_x=%b, required 0", bus.hazard_x);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        issue(3'b101, 32'd1000, 32'd3, 1'b0);
        @(negedge clk);
        bus.div_inst = 3'b000;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors += 3;
        if ({bus.hazard_x, bus.div_wb, bus.RSIGN} !== 3'b000) begin
            miscompares++;
            $display("FAIL midreset_flags: got %b, required 000", {bus.hazard_x, bus.div_wb, bus.RSIGN});
        end
        if (bus.Qo !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_Qo: got %h, required 00000000", bus.Qo);
        end
        if (bus.Ro !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_Ro: got %h, required 00000000", bus.Ro);
        end
        reset = 1'b1;
        repeat (40) @(negedge clk);
        issue(3'b101, 32'd1, 32'd1, 1'b1);
        @(negedge clk);
        bus.div_inst = 3'b000;
        wait_drain("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [3];
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        ops[0] = 3'b001;
        ops[1] = 3'b010;
        ops[2] = 3'b011;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i == 2) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
            if (i == 4) b = 32'hFFFF_FFF0;
            issue(ops[i % 3], a, b, 1'b1);
            hold = exp_q[$].cyc - cyc;
            repeat (hold) @(negedge clk);
            if (i == 5) bus.div_inst = 3'b000;
            @(negedge clk);
        end
        wait_drain("back_to_back");
    endtask

    initial begin
        bus.div_inst = 3'b000;
        bus.div_kill = 1'b0;
        bus.rs1_data = 32'h0;
        bus.rs2_data = 32'h0;
        reset        = 1'b0;
        @(negedge clk);
        test_reset();
        test_signed();
        test_unsigned_hold();
        test_specials();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by cycle %0d, required finish", cyc);
        $fatal(1);
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring integer divider. It is the responder to the execute stage's divide request (div_inst) and produces Qo, Ro, RSIGN and div_wb.
- Serves RV32M DIV/DIVU/REM/REMU.
- Sits beside the execute stage and stalls it via hazard_x while a division is in flight.
- Contains its own subtractor, so the execute ALU is not borrowed.

Parameters:
- XLEN, 32: operand and result width.
- STEPS_PER_CYCLE, 1: restoring steps per RUN cycle. Legal values are 1 or 2. RUN length = XLEN/STEPS_PER_CYCLE cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- div_inst  in  3  request: [0] signed start, [1] unsigned start, [2] signed-quotient op (DIV). Zero means no request.
- div_kill  in  1  abort the in-flight division (pipeline flush).
- rs1_data  in  XLEN  dividend, sampled at start.
- rs2_data  in  XLEN  divisor, sampled at start.
- hazard_x  out  1  busy; execute must hold.
- div_wb  out  1  one-cycle pulse: Qo/Ro valid, instruction retires.
- Qo  out  XLEN  quotient.
- Ro  out  XLEN  remainder.
- RSIGN  out  1  sign of the latched dividend (signed ops only, else 0).

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; hazard_x=0, div_wb=0, Qo=0, Ro=0, RSIGN=0.
  - Reset during any state aborts with no div_wb.
- State machine: IDLE, RUN, FIX, DONE.
- IDLE:
  - Start condition: div_inst[1:0]!=0.
  - On start, latch |rs1| and |rs2| (plain values if unsigned), sign_a, sign_b, signed flag, zero-divisor flag and overflow flag (signed, rs1=0x80000000, rs2=-1).
  - Clear the partial remainder and the step counter. Next state is RUN.
  - If div_inst[1:0]==2'b11, it is treated as signed.
- RUN:
  - Each cycle performs STEPS_PER_CYCLE restoring steps. Each step: shift {rem,quo} left 1, trial-subtract the divisor using an XLEN+1-bit subtract, and keep the result and set the quotient bit if it is non-negative.
  - After XLEN steps, go to FIX.
- FIX (sign and special-case correction):
  - Signed: Qo = (sign_a^sign_b) ? -quo : quo; Ro = sign_a ? -rem : rem.
  - Divide by zero: Qo=all ones, Ro=original dividend. This overrides the signed negation.
  - Overflow: Qo=0x80000000, Ro=0.
  - Unsigned: Qo=quo, Ro=rem.
  - Next state is DONE.
- DONE:
  - div_wb=1 for exactly this cycle; hazard_x=0.
  - div_inst is ignored in this cycle, because the same instruction is still presented by execute and must not restart.
  - Next state is IDLE.
- hazard_x is purely registered: 1 in RUN and FIX, 0 in IDLE and DONE. There is no combinational path from div_inst to hazard_x, which avoids a loop with execute's issue-valid.
- Latency, start sampled in cycle T:
  - div_wb at T+XLEN/STEPS_PER_CYCLE+2, i.e. T+34 for the defaults.
  - Back-to-back: a new start is accepted no earlier than T+35.
- div_kill:
  - In RUN or FIX, the next state is IDLE, there is no div_wb, and Qo/Ro are unchanged.
  - In DONE, div_kill is ignored: the result is already written back.
  - In IDLE, div_kill has priority over start, so the start is not accepted.
- Qo, Ro and RSIGN are updated only in FIX and hold until the next FIX.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined:
  - At start, if the divisor is zero, the op is an overflow, or |dividend| < |divisor| (unsigned compare of the latched magnitudes), skip RUN and go IDLE→FIX→DONE, so div_wb is at T+2.
  - FIX uses quo=0 and rem=|dividend| for the small-dividend case. Special cases are as above.
- Undefined: every division runs full length. Results are identical either way.

Decomposition:
- instruction_pkg gains:
  - the div_state_t enum (IDLE, RUN, FIX, DONE);
  - div_inst bit-index constants;
  - DIV_ZERO_Q (all ones) and DIV_OVF_Q (0x80000000) constants.
- Sub-module div_step: one combinational restoring step. Inputs rem, quo, divisor; outputs next rem and next quo. It is instantiated STEPS_PER_CYCLE times in a chain.

Test Plan:
- Signed 100/7: div_inst=101, rs1=100, rs2=7 → hazard_x high T+1..T+33; at T+34 div_wb=1, Qo=14, Ro=2, RSIGN=0, hazard_x=0.
- Signed -100/7 (rs1=0xFFFFFF9C) → Qo=0xFFFFFFF2 (-14), Ro=0xFFFFFFFE (-2), RSIGN=1.
- Unsigned 0xFFFFFFFF/2 with div_inst=010 → Qo=0x7FFFFFFF, Ro=1. Also assert that div_inst held at 010 during the DONE cycle does not restart the divider.
- Specials:
  - -5/0 signed → Qo=0xFFFFFFFF, Ro=0xFFFFFFFB.
  - 0x80000000/0xFFFFFFFF signed → Qo=0x80000000, Ro=0.
  - With DIV_FAST_PATH_EN, both have div_wb at T+2.
- div_kill asserted at T+10 → IDLE at T+11, no div_wb, Qo/Ro retain previous values. A new 9/3 start at T+12 → Qo=3, Ro=0 at T+46.
- reset=0 at T+20 mid-RUN → all outputs 0 the next cycle, no div_wb. After release, 1/1 → Qo=1, Ro=0.
